// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants for the exception/ERTN commit controller: Ecode/EsubCode values
// and the FSM state encoding.
package exc_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Combinational priority encoder: WB exception flags and the sampled interrupt
// collapse to a single {hit, ecode, esubcode}.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic       has_int_i,
  input  logic       exc_adef_i,
  input  logic       exc_ine_i,
  input  logic       exc_sys_i,
  input  logic       exc_brk_i,
  input  logic       exc_ale_i,
  output logic       hit_o,
  output logic [5:0] ecode_o,
  output logic [8:0] esubcode_o
);

  always_comb begin
    hit_o      = 1'b1;
    ecode_o    = ECODE_INT;
    esubcode_o = ESUBCODE_NONE;
    if (has_int_i)       ecode_o = ECODE_INT;
    else if (exc_adef_i) ecode_o = ECODE_ADEF;
    else if (exc_ine_i)  ecode_o = ECODE_INE;
    else if (exc_sys_i)  ecode_o = ECODE_SYS;
    else if (exc_brk_i)  ecode_o = ECODE_BRK;
    else if (exc_ale_i)  ecode_o = ECODE_ALE;
    else                 hit_o   = 1'b0;
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERTN commit sequencer between WB and CSR_Unit: pulses the CSR commit,
// holds flush, hands the redirect PC to Pre-IF, then drains before re-admitting WB.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc_in,
  input  logic        has_int,
  input  logic        exc_adef,
  input  logic        exc_ine,
  input  logic        exc_sys,
  input  logic        exc_brk,
  input  logic        exc_ale,
  input  logic        is_ertn,
  input  logic [31:0] ex_entry,
  input  logic [31:0] csr_era,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  state_e           state_q, state_d;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      pc_q, pc_d;
  logic             ertn_q, ertn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       enc_hit;
  logic [5:0] enc_ecode;
  logic [8:0] enc_esub;
  logic       commit_event;

  exc_prio_enc u_prio_enc (
    .has_int_i  (has_int),
    .exc_adef_i (exc_adef),
    .exc_ine_i  (exc_ine),
    .exc_sys_i  (exc_sys),
    .exc_brk_i  (exc_brk),
    .exc_ale_i  (exc_ale),
    .hit_o      (enc_hit),
    .ecode_o    (enc_ecode),
    .esubcode_o (enc_esub)
  );

  assign commit_event = wb_valid & (enc_hit | is_ertn);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ecode_q <= '0;
      esub_q  <= '0;
      pc_q    <= '0;
      ertn_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ecode_q <= ecode_d;
      esub_q  <= esub_d;
      pc_q    <= pc_d;
      ertn_q  <= ertn_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ecode_d        = ecode_q;
    esub_d         = esub_q;
    pc_d           = pc_q;
    ertn_d         = ertn_q;
    cnt_d          = cnt_q;
    wb_ready       = 1'b0;
    wb_ex          = 1'b0;
    wb_ecode       = '0;
    wb_esubcode    = '0;
    wb_pc          = '0;
    ertn_flush     = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_q)
      ST_IDLE: begin
        wb_ready = 1'b1;
        if (commit_event) begin
          // An exception on the ERTN itself wins and suppresses the ERTN.
          ecode_d = enc_hit ? enc_ecode : '0;
          esub_d  = enc_hit ? enc_esub : '0;
          ertn_d  = ~enc_hit;
          pc_d    = wb_pc_in;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        wb_ex       = ~ertn_q;
        ertn_flush  = ertn_q;
        wb_ecode    = ecode_q;
        wb_esubcode = esub_q;
        wb_pc       = pc_q;
        flush       = 1'b1;
        state_d     = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        // CSR_Unit has already absorbed the commit, so EENTRY/ERA are stable here.
        redirect_pc    = ertn_q ? csr_era : ex_entry;
        if (redirect_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = CNT_W'(DRAIN_CYCLES);
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: exception/ERTN commit, priority, redirect
// backpressure, WB stall while busy and asynchronous abort.
module tb_exc_commit_ctrl;

  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_pc_in;
  logic        has_int, exc_adef, exc_ine, exc_sys, exc_brk, exc_ale, is_ertn;
  logic [31:0] ex_entry, csr_era;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush, flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int errs    = 0;
  int ex_cnt  = 0;
  int ertn_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_ex === 1'b1) ex_cnt++;
    if (ertn_flush === 1'b1) ertn_cnt++;
  end

  exc_commit_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pc_in       (wb_pc_in),
    .has_int        (has_int),
    .exc_adef       (exc_adef),
    .exc_ine        (exc_ine),
    .exc_sys        (exc_sys),
    .exc_brk        (exc_brk),
    .exc_ale        (exc_ale),
    .is_ertn        (is_ertn),
    .ex_entry       (ex_entry),
    .csr_era        (csr_era),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_pc          (wb_pc),
    .ertn_flush     (ertn_flush),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_flags();
    wb_valid = 0; has_int = 0; exc_adef = 0; exc_ine = 0;
    exc_sys = 0; exc_brk = 0; exc_ale = 0; is_ertn = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (wb_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, wb_ready}, 32'd1);
  endtask

  int base;

  initial begin
    resetn = 0;
    clear_flags();
    wb_pc_in = 0; ex_entry = 0; csr_era = 0; redirect_ready = 0;
    #12;
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_wb_ex", {31'd0, wb_ex}, 32'd0);
    chk("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    #10 resetn = 1;
    cyc();
    chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);

    // Non-event commit and ignored flags with wb_valid low
    wb_valid = 1; wb_pc_in = 32'h1C000000;
    cyc();
    chk("plain_commit_idle", {31'd0, wb_ready}, 32'd1);
    wb_valid = 0; has_int = 1; exc_sys = 1;
    cyc();
    chk("novalid_ignored", {30'd0, wb_ready, flush}, 32'd2);
    clear_flags();
    cyc();

    // 1: SYSCALL
    wb_valid = 1; exc_sys = 1; wb_pc_in = 32'h1C000100;
    ex_entry = 32'h1C008000; redirect_ready = 1;
    cyc();
    clear_flags();
    chk("t1_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("t1_ecode", {26'd0, wb_ecode}, 32'h0B);
    chk("t1_esub", {23'd0, wb_esubcode}, 32'h0);
    chk("t1_wb_pc", wb_pc, 32'h1C000100);
    chk("t1_ertn", {31'd0, ertn_flush}, 32'd0);
    chk("t1_flush_c", {31'd0, flush}, 32'd1);
    chk("t1_ready_busy", {31'd0, wb_ready}, 32'd0);
    cyc();
    chk("t1_wb_ex_off", {31'd0, wb_ex}, 32'd0);
    chk("t1_ecode_off", {26'd0, wb_ecode}, 32'h0);
    chk("t1_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("t1_rpc", redirect_pc, 32'h1C008000);
    chk("t1_flush_r", {31'd0, flush}, 32'd1);
    for (int i = 0; i < DC; i++) begin
      cyc();
      chk("t1_flush_d", {31'd0, flush}, 32'd1);
      chk("t1_rvalid_d", {31'd0, redirect_valid}, 32'd0);
    end
    cyc();
    chk("t1_flush_end", {31'd0, flush}, 32'd0);
    chk("t1_idle", {31'd0, wb_ready}, 32'd1);

    // 2: ERTN
    wb_valid = 1; is_ertn = 1; wb_pc_in = 32'h1C000300; csr_era = 32'h1C000204;
    cyc();
    clear_flags();
    chk("t2_ertn_flush", {31'd0, ertn_flush}, 32'd1);
    chk("t2_wb_ex", {31'd0, wb_ex}, 32'd0);
    cyc();
    chk("t2_ertn_off", {31'd0, ertn_flush}, 32'd0);
    chk("t2_rpc", redirect_pc, 32'h1C000204);
    wait_idle("t2_idle");

    // ERTN carrying an exception: exception wins
    wb_valid = 1; is_ertn = 1; exc_adef = 1;
    cyc();
    clear_flags();
    chk("t2b_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("t2b_ertn", {31'd0, ertn_flush}, 32'd0);
    chk("t2b_ecode", {26'd0, wb_ecode}, 32'h08);
    cyc();
    chk("t2b_rpc", redirect_pc, 32'h1C008000);
    wait_idle("t2b_idle");

    // 3: priority
    wb_valid = 1; has_int = 1; exc_ine = 1; exc_ale = 1;
    cyc();
    clear_flags();
    chk("t3_int_ex", {31'd0, wb_ex}, 32'd1);
    chk("t3_int_ecode", {26'd0, wb_ecode}, 32'h00);
    wait_idle("t3_idle_a");
    wb_valid = 1; exc_ine = 1; exc_ale = 1;
    cyc();
    clear_flags();
    chk("t3_ine_ecode", {26'd0, wb_ecode}, 32'h0D);
    wait_idle("t3_idle_b");
    wb_valid = 1; exc_ale = 1;
    cyc();
    clear_flags();
    chk("t3_ale_ecode", {26'd0, wb_ecode}, 32'h09);
    wait_idle("t3_idle_c");

    // 4: redirect backpressure
    redirect_ready = 0; ex_entry = 32'h1C00A000;
    wb_valid = 1; exc_brk = 1;
    cyc();
    clear_flags();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_rvalid", {31'd0, redirect_valid}, 32'd1);
      chk("t4_rpc", redirect_pc, 32'h1C00A000);
      chk("t4_wb_ready", {31'd0, wb_ready}, 32'd0);
    end
    redirect_ready = 1;
    for (int i = 0; i < DC; i++) begin
      cyc();
      chk("t4_drain", {30'd0, wb_ready, flush}, 32'd1);
    end
    cyc();
    chk("t4_idle", {30'd0, wb_ready, flush}, 32'd2);

    // 5: back-to-back while busy
    base = ex_cnt;
    wb_valid = 1; exc_sys = 1;
    cyc();
    chk("t5_first", {26'd0, wb_ecode}, 32'h0B);
    exc_sys = 0; exc_brk = 1;
    wait_idle("t5_stall");
    cyc();
    clear_flags();
    chk("t5_second_ex", {31'd0, wb_ex}, 32'd1);
    chk("t5_second_ecode", {26'd0, wb_ecode}, 32'h0C);
    wait_idle("t5_idle");
    cyc();
    chk("t5_pulses", ex_cnt - base, 32'd2);

    // 6: async reset during REDIRECT
    redirect_ready = 0;
    wb_valid = 1; exc_sys = 1;
    cyc();
    clear_flags();
    cyc();
    chk("t6_in_redirect", {31'd0, redirect_valid}, 32'd1);
    #1 resetn = 0;
    #1;
    chk("t6_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("t6_flush", {31'd0, flush}, 32'd0);
    chk("t6_rpc", redirect_pc, 32'h0);
    chk("t6_ready", {31'd0, wb_ready}, 32'd1);
    #1 resetn = 1;
    base = ex_cnt + ertn_cnt;
    cyc();
    chk("t6_post_ready", {31'd0, wb_ready}, 32'd1);
    cyc(); cyc(); cyc();
    chk("t6_no_pulse", ex_cnt + ertn_cnt - base, 32'd0);
    chk("t6_no_flush", {31'd0, flush}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
